// File: rtl/echo_cancel_sequencer.sv
// Start/ready handshake sequencer for the per-sample echo-cancellation datapath.
// Optional per-stage timeout watchdog is built when ECHO_SEQ_TIMEOUT_EN is defined.
module echo_cancel_sequencer #(
   parameter int unsigned TRAIN_SAMPLES = 4000,
   parameter int unsigned WARMUP_FRAMES = 2,
   parameter int unsigned TIMEOUT       = 4095
) (
   input  logic        clk_operation,
   input  logic        rst,
   input  logic        enable,
   input  logic [12:0] sampling_cycle_counter,
   input  logic        retrain,
   input  logic        conv_ready_a,
   input  logic        conv_ready_b,
   input  logic        adapt_ready,
   input  logic        cancel_ready,
   output logic        conv_start,
   output logic        adapt_start,
   output logic        cancel_start,
   output logic        out_start,
   output logic        out_sel,
   output logic        sampling_en_cancel,
   output logic        sampling_en_adapt,
   output logic        training,
   output logic        busy,
   output logic        err_timeout,
   output logic        err_overrun,
   output logic [15:0] frame_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CONV   = 3'd1;
   localparam logic [2:0] S_ADAPT  = 3'd2;
   localparam logic [2:0] S_CANCEL = 3'd3;
   localparam logic [2:0] S_OUT    = 3'd4;

   localparam int unsigned WARM_MAX = 2 * WARMUP_FRAMES;
   localparam int unsigned WW       = $clog2(WARM_MAX + 1);

   logic [2:0]    state;
   logic          trig_cond;
   logic          trig_d;
   logic          trig;
   logic [1:0]    blank;
   logic          stage_rdy;
   logic          accept;
   logic          tmo_hit;
   logic          retrain_pend;
   logic          apply_rt;
   logic [WW-1:0] warm_cnt;
   logic [15:0]   fc_next;

   assign trig_cond          = enable && (sampling_cycle_counter == 13'd0);
   assign busy               = (state != S_IDLE);
   assign fc_next            = frame_count + 16'd1;
   assign sampling_en_cancel = (warm_cnt >= WW'(WARMUP_FRAMES));
   assign sampling_en_adapt  = (warm_cnt >= WW'(WARM_MAX));

   always_comb begin
      stage_rdy = 1'b0;
      case (state)
         S_CONV:   stage_rdy = conv_ready_a && conv_ready_b;
         S_ADAPT:  stage_rdy = adapt_ready;
         S_CANCEL: stage_rdy = cancel_ready;
         default:  stage_rdy = 1'b0;
      endcase
   end

   // A ready is only honoured once the 2-cycle blanking window after its start has expired.
   assign accept   = (blank == 2'd0) && stage_rdy;
   assign apply_rt = (retrain || retrain_pend) &&
                     ((state == S_IDLE) || (state == S_OUT) || tmo_hit);

`ifdef ECHO_SEQ_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic          waiting;

   assign waiting = (state == S_CONV) || (state == S_ADAPT) || (state == S_CANCEL);
   assign tmo_hit = waiting && !accept && (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk_operation or posedge rst) begin
      if (rst) begin
         tcnt        <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (!waiting || accept || tmo_hit) tcnt <= '0;
         else                               tcnt <= tcnt + TW'(1);
         if (tmo_hit) err_timeout <= 1'b1;
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk_operation or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         trig_d       <= 1'b0;
         trig         <= 1'b0;
         blank        <= 2'd0;
         conv_start   <= 1'b0;
         adapt_start  <= 1'b0;
         cancel_start <= 1'b0;
         out_start    <= 1'b0;
         out_sel      <= 1'b0;
         training     <= 1'b1;
         frame_count  <= '0;
         retrain_pend <= 1'b0;
         err_overrun  <= 1'b0;
         warm_cnt     <= '0;
      end else begin
         trig_d       <= trig_cond;
         trig         <= trig_cond && !trig_d;
         conv_start   <= 1'b0;
         adapt_start  <= 1'b0;
         cancel_start <= 1'b0;
         out_start    <= 1'b0;
         if (blank != 2'd0) blank <= blank - 2'd1;
         if (trig && (warm_cnt != WW'(WARM_MAX))) warm_cnt <= warm_cnt + WW'(1);
         if (trig && busy) err_overrun <= 1'b1;

         // A retrain seen mid-sequence is parked until the FSM is back at IDLE.
         if (apply_rt) begin
            training     <= 1'b1;
            frame_count  <= '0;
            retrain_pend <= 1'b0;
         end else if (retrain) begin
            retrain_pend <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (trig) begin
                  state      <= S_CONV;
                  conv_start <= 1'b1;
                  blank      <= 2'd2;
               end
            end
            S_CONV: begin
               if (accept) begin
                  blank <= 2'd2;
                  if (training) begin
                     state       <= S_ADAPT;
                     adapt_start <= 1'b1;
                  end else begin
                     state        <= S_CANCEL;
                     cancel_start <= 1'b1;
                  end
               end else if (tmo_hit) begin
                  state <= S_IDLE;
               end
            end
            S_ADAPT: begin
               if (accept) begin
                  state        <= S_CANCEL;
                  cancel_start <= 1'b1;
                  blank        <= 2'd2;
               end else if (tmo_hit) begin
                  state <= S_IDLE;
               end
            end
            S_CANCEL: begin
               if (accept) begin
                  state     <= S_OUT;
                  out_start <= 1'b1;
                  out_sel   <= training;
                  if (training) begin
                     frame_count <= fc_next;
                     if (fc_next == 16'(TRAIN_SAMPLES)) training <= 1'b0;
                  end
               end else if (tmo_hit) begin
                  state <= S_IDLE;
               end
            end
            S_OUT:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_echo_cancel_sequencer.sv
// Directed self-checking bench for echo_cancel_sequencer (TRAIN_SAMPLES=3, TIMEOUT=20).
module tb_echo_cancel_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [12:0] sampling_cycle_counter;
   logic        retrain;
   logic        conv_ready_a, conv_ready_b, adapt_ready, cancel_ready;
   logic        conv_start, adapt_start, cancel_start, out_start, out_sel;
   logic        sampling_en_cancel, sampling_en_adapt, training, busy;
   logic        err_timeout, err_overrun;
   logic [15:0] frame_count;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   echo_cancel_sequencer #(
      .TRAIN_SAMPLES(3),
      .WARMUP_FRAMES(2),
      .TIMEOUT(20)
   ) dut (
      .clk_operation(clk),
      .rst(rst),
      .enable(enable),
      .sampling_cycle_counter(sampling_cycle_counter),
      .retrain(retrain),
      .conv_ready_a(conv_ready_a),
      .conv_ready_b(conv_ready_b),
      .adapt_ready(adapt_ready),
      .cancel_ready(cancel_ready),
      .conv_start(conv_start),
      .adapt_start(adapt_start),
      .cancel_start(cancel_start),
      .out_start(out_start),
      .out_sel(out_sel),
      .sampling_en_cancel(sampling_en_cancel),
      .sampling_en_adapt(sampling_en_adapt),
      .training(training),
      .busy(busy),
      .err_timeout(err_timeout),
      .err_overrun(err_overrun),
      .frame_count(frame_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle zero on the sample counter; returns just after the edge that registers the trigger.
   task automatic fire();
      sampling_cycle_counter = 13'd0;
      step();
      sampling_cycle_counter = 13'd1;
   endtask

   task automatic run_frame(input string tag, input bit trn, input int fc_exp);
      int kc = -1, ka = -1, kx = -1, ko = -1;
      int nc = 0, na = 0, nx = 0, no = 0;
      int ko_exp;
      logic sel = 1'bx;
      logic [15:0] fcv = 'x;
      logic bz [0:15];
      ko_exp = trn ? 10 : 7;
      fire();
      for (int k = 1; k <= 15; k++) begin
         step();
         if (conv_start)   begin if (kc < 0) kc = k; nc++; end
         if (adapt_start)  begin if (ka < 0) ka = k; na++; end
         if (cancel_start) begin if (kx < 0) kx = k; nx++; end
         if (out_start)    begin if (ko < 0) ko = k; no++; sel = out_sel; fcv = frame_count; end
         bz[k] = busy;
      end
      chk({tag, ".conv_at"}, kc, 1);
      chk({tag, ".conv_n"}, nc, 1);
      if (trn) begin
         chk({tag, ".adapt_at"}, ka, 4);
         chk({tag, ".adapt_n"}, na, 1);
      end else begin
         chk({tag, ".adapt_n"}, na, 0);
      end
      chk({tag, ".cancel_at"}, kx, trn ? 7 : 4);
      chk({tag, ".cancel_n"}, nx, 1);
      chk({tag, ".out_at"}, ko, ko_exp);
      chk({tag, ".out_n"}, no, 1);
      chk({tag, ".out_sel"}, sel, trn);
      chk({tag, ".frame_count"}, fcv, fc_exp);
      chk({tag, ".busy_conv"}, bz[1], 1'b1);
      chk({tag, ".busy_out"}, bz[ko_exp], 1'b1);
      chk({tag, ".busy_after"}, bz[ko_exp + 1], 1'b0);
   endtask

   task automatic wait_out(input string tag, input logic sel_exp, input int fc_exp);
      bit got = 0;
      int nconv = 0;
      for (int k = 0; k < 12 && !got; k++) begin
         step();
         if (conv_start) nconv++;
         if (out_start) begin
            got = 1;
            chk({tag, ".out_sel"}, out_sel, sel_exp);
            chk({tag, ".frame_count"}, frame_count, fc_exp);
         end
      end
      chk({tag, ".out_seen"}, got, 1'b1);
      chk({tag, ".no_conv"}, nconv, 0);
      step();
      chk({tag, ".busy_after"}, busy, 1'b0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".conv"}, conv_start, 1'b0);
      chk({tag, ".adapt"}, adapt_start, 1'b0);
      chk({tag, ".cancel"}, cancel_start, 1'b0);
      chk({tag, ".out"}, out_start, 1'b0);
      chk({tag, ".out_sel"}, out_sel, 1'b0);
      chk({tag, ".en_cancel"}, sampling_en_cancel, 1'b0);
      chk({tag, ".en_adapt"}, sampling_en_adapt, 1'b0);
      chk({tag, ".training"}, training, 1'b1);
      chk({tag, ".busy"}, busy, 1'b0);
      chk({tag, ".err_timeout"}, err_timeout, 1'b0);
      chk({tag, ".err_overrun"}, err_overrun, 1'b0);
      chk({tag, ".frame_count"}, frame_count, 16'd0);
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b1;
      sampling_cycle_counter = 13'd1;
      retrain = 1'b0;
      conv_ready_a = 1'b1;
      conv_ready_b = 1'b1;
      adapt_ready = 1'b1;
      cancel_ready = 1'b1;

      // reset values and warm-up through the training phase
      #2;
      chk_reset("rst0");
      step();
      step();
      rst = 1'b0;
      step();
      chk_reset("rst0_rel");

      run_frame("f1", 1'b1, 1);
      chk("f1.en_cancel", sampling_en_cancel, 1'b0);
      run_frame("f2", 1'b1, 2);
      chk("f2.en_cancel", sampling_en_cancel, 1'b1);
      chk("f2.en_adapt", sampling_en_adapt, 1'b0);
      run_frame("f3", 1'b1, 3);
      chk("f3.training", training, 1'b0);
      chk("f3.en_adapt", sampling_en_adapt, 1'b0);
      run_frame("f4", 1'b0, 3);
      chk("f4.en_adapt", sampling_en_adapt, 1'b1);
      chk("f4.training", training, 1'b0);

      // overrun: second trigger lands while stuck in CANCEL
      cancel_ready = 1'b0;
      fire();
      for (int k = 1; k <= 10; k++) step();
      chk("ovr.pre", err_overrun, 1'b0);
      chk("ovr.busy_pre", busy, 1'b1);
      fire();
      step();
      chk("ovr.set", err_overrun, 1'b1);
      chk("ovr.busy", busy, 1'b1);
      cancel_ready = 1'b1;
      wait_out("ovr", 1'b0, 3);
      chk("ovr.sticky", err_overrun, 1'b1);

      // retrain during CANCEL of a frozen frame is deferred to IDLE
      cancel_ready = 1'b0;
      fire();
      for (int k = 1; k <= 6; k++) step();
      retrain = 1'b1;
      step();
      retrain = 1'b0;
      chk("rt.training_held", training, 1'b0);
      chk("rt.fc_held", frame_count, 16'd3);
      cancel_ready = 1'b1;
      wait_out("rt", 1'b0, 3);
      chk("rt.training", training, 1'b1);
      chk("rt.fc_clear", frame_count, 16'd0);
      run_frame("rt_f1", 1'b1, 1);

`ifdef ECHO_SEQ_TIMEOUT_EN
      begin
         int ka = -1, kt = -1, ncx = 0, nout = 0;
         adapt_ready = 1'b0;
         fire();
         for (int k = 1; k <= 30; k++) begin
            step();
            if (adapt_start && ka < 0) ka = k;
            if (err_timeout && kt < 0) kt = k;
            if (cancel_start) ncx++;
            if (out_start) nout++;
         end
         chk("tmo.adapt_at", ka, 4);
         chk("tmo.err_at", kt, 24);
         chk("tmo.cancel_n", ncx, 0);
         chk("tmo.out_n", nout, 0);
         chk("tmo.busy", busy, 1'b0);
         chk("tmo.fc", frame_count, 16'd1);
         adapt_ready = 1'b1;
      end
`else
      chk("tmo.tied", err_timeout, 1'b0);
`endif

      // asynchronous reset between edges while in CONV
      conv_ready_a = 1'b0;
      fire();
      step();
      chk("arst.conv", conv_start, 1'b1);
      step();
      chk("arst.busy_pre", busy, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      chk_reset("arst");
      step();
      chk("arst.edge_busy", busy, 1'b0);
      chk("arst.edge_conv", conv_start, 1'b0);
      rst = 1'b0;
      conv_ready_a = 1'b1;
      step();
      run_frame("arst_f1", 1'b1, 1);
      chk("arst_f1.en_cancel", sampling_en_cancel, 1'b0);
      run_frame("arst_f2", 1'b1, 2);
      chk("arst_f2.en_cancel", sampling_en_cancel, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/echo_cancel_sequencer.md
# echo_cancel_sequencer

Cycle-accurate controller that sequences the per-sample echo-cancellation datapath: the two 16-bit-to-double converters, the NLMS parameter-adaptation stage, the echo-subtraction stage and the double-to-16-bit output converter. It replaces delay-based sequencing with a start/ready handshake FSM. It also manages the warm-up, training and frozen-coefficient phases, and flags timeouts and sample overruns. It sits between the sampling-cycle counter and the datapath enables in the full echo-cancellation top level.

## Interface
- TRAIN_SAMPLES, 4000: completed training frames before the coefficients freeze.
- WARMUP_FRAMES, 2: frame triggers before each sampling-enable stage asserts.
- TIMEOUT, 4095: maximum cycles spent waiting in one stage.
- clk_operation  in  1  operation clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  sequencer run enable.
- sampling_cycle_counter  in  13  sample-phase counter; value 0 marks a new sample.
- retrain  in  1  one-cycle pulse that restarts the training phase.
- conv_ready_a, conv_ready_b  in  1  converter done (send path, lag path).
- adapt_ready, cancel_ready  in  1  adaptation and cancellation stages done.
- conv_start, adapt_start, cancel_start, out_start  out  1  one-cycle start pulses.
- out_sel  out  1  selects the output double: 1 = adaptation error e, 0 = signal_without_echo. Valid with out_start.
- sampling_en_cancel, sampling_en_adapt  out  1  staged enable_sampling outputs.
- training  out  1  training phase active.
- busy  out  1  FSM not in IDLE.
- err_timeout, err_overrun  out  1  sticky error flags.
- frame_count  out  16  frames completed in the current training phase.

## Operation
- **Trigger:** registered rising edge of (enable && sampling_cycle_counter==0). One trigger per run of zeros.
- **FSM states:** IDLE, CONV, ADAPT, CANCEL, OUT.
- **IDLE:** on trigger, pulse conv_start and go to CONV.
- **CONV:** wait for conv_ready_a && conv_ready_b.
  - If training=1: pulse adapt_start and go to ADAPT.
  - Otherwise: pulse cancel_start and go to CANCEL.
- **ADAPT:** wait for adapt_ready, then pulse cancel_start and go to CANCEL.
- **CANCEL:** wait for cancel_ready, then go to OUT.
- **OUT:** pulse out_start with out_sel=training and return to IDLE. If training=1, increment frame_count in the same cycle.
- **Ready blanking:** each ready is ignored for the first 2 cycles after its start pulse, so stale ready levels are not accepted.
- **Training exit:** when frame_count reaches TRAIN_SAMPLES, training clears and frame_count holds its value.
- **Retrain:** a retrain pulse sets training=1 and clears frame_count. If the FSM is busy, the retrain takes effect at the next return to IDLE.
- **Warm-up:** count triggers after reset, saturating at 2*WARMUP_FRAMES.
  - sampling_en_cancel asserts once the count reaches WARMUP_FRAMES.
  - sampling_en_adapt asserts once the count reaches 2*WARMUP_FRAMES.
- **Overrun:** a trigger while busy=1 sets err_overrun and is dropped. The current sequence continues.
- **enable low mid-sequence:** the sequence completes; no new triggers are accepted.
- **Simultaneous events:** when both readies of CONV rise in different cycles, the later one completes the stage. A trigger in the same cycle as the OUT→IDLE transition is an overrun.

## Timing
- **Reset values:** all pulses 0, out_sel 0, sampling_en_* 0, training 1, busy 0, err_* 0, frame_count 0, state IDLE.
- **Trigger:** trigger registered at edge T; conv_start high during cycle T+1.
- **Stage handoff:** the next start pulse is issued the cycle after the accepting ready sample.
- **Minimum latency with readies high** (trigger to out_start):
  - Training: 3+3+3+1 = 10 cycles.
  - Frozen: 7 cycles.
- **Pulse width:** every start pulse is exactly 1 cycle wide.
- **Status flags:** busy rises with conv_start and falls the cycle after out_start.
- **Reset mid-sequence:** returns to IDLE immediately; no pulses are emitted.

## Configuration
- **ECHO_SEQ_TIMEOUT_EN defined:**
  - A per-stage cycle counter runs in each wait state.
  - Reaching TIMEOUT in CONV/ADAPT/CANCEL sets err_timeout and forces IDLE with no out_start. frame_count does not change.
- **Undefined:** stages wait indefinitely; err_timeout is tied 0 and the counter is not built.

## Test plan
- **Reset and warm-up:** rst pulse; counter wraps every 100 cycles with readies tied high → after rst all outputs at reset values. After 2 triggers sampling_en_cancel=1; after 4 sampling_en_adapt=1. Each training frame shows conv, adapt, cancel, out pulses, with out_start 10 cycles after the trigger and out_sel=1.
- **Training exit:** TRAIN_SAMPLES=3 → frames 1-3 have out_sel=1 and frame_count reaches 3. Frame 4 skips adapt_start, out_start comes 7 cycles after the trigger, and out_sel=0.
- **Overrun:** cancel_ready held low for 150 cycles → the second trigger sets err_overrun=1. The sequence still finishes when cancel_ready rises; err_overrun stays 1 until rst.
- **Timeout (macro defined, TIMEOUT=20):** adapt_ready held low → err_timeout=1 exactly 20 cycles after entering ADAPT. No cancel_start or out_start occurs, busy=0, and frame_count is unchanged.
- **Retrain mid-sequence:** retrain pulse in the frozen phase while in CANCEL → the current frame completes with out_sel=0. training=1 from IDLE; the next frame includes adapt_start and frame_count restarts at 1.
- **Asynchronous reset mid-CONV:** rst asserted between clock edges → busy=0 and no pulses before the next edge; restart behaves as in the first scenario.
